// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/requester types and access-type constants for mem_req_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    typedef enum logic {SRC_I, SRC_D} src_t;
    localparam logic [2:0] TYPE_BYTE = 3'd0;
    localparam logic [2:0] TYPE_HALF = 3'd1;
    localparam logic [2:0] TYPE_WORD = 3'd2;
    localparam logic [2:0] TYPE_ALL_ONES = 3'b111;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin picker remembering the last completed grant
module mem_arb_rr
    import mem_arb_pkg::*;
#(
    parameter int D_FIRST = 1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       upd_src,
    output logic       gnt
);
    src_t last_gnt_q, last_gnt_d;

    // Remember the winner only when its transaction completes
    always_comb last_gnt_d = upd ? src_t'(upd_src) : last_gnt_q;

    // A sole requester wins; on a tie the side that did not go last wins
    always_comb gnt = (req == 2'b11) ? (last_gnt_q == SRC_I) : req[1];

    // Last-grant register; reset value decides who wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_gnt_q <= (D_FIRST != 0) ? SRC_I : SRC_D;
        else     last_gnt_q <= last_gnt_d;
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one master front-end between I-side and D-side requesters
// Optional perf counters enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TYPE_W  = 3,
    parameter int D_FIRST = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_wait,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [TYPE_W-1:0] d_type,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wait,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_read,
    output logic              m_write,
    output logic [TYPE_W-1:0] m_type,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_stall,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts
);
    state_t            state_q, state_d;
    logic              lat_write_q, lat_write_d;
    logic [TYPE_W-1:0] lat_type_q, lat_type_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              rr_gnt, rr_upd, rr_src;

    mem_arb_rr #(.D_FIRST(D_FIRST)) u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({d_req, i_req}),
        .upd    (rr_upd),
        .upd_src(rr_src),
        .gnt    (rr_gnt)
    );

    // Grant FSM: pick and latch in IDLE, hold the master until the stall drops
    always_comb begin
        state_d     = state_q;
        lat_write_d = lat_write_q;
        lat_type_d  = lat_type_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        rr_upd      = 1'b0;
        rr_src      = SRC_I;
        i_wait      = 1'b0;
        d_wait      = 1'b0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        case (state_q)
            IDLE: begin
                i_wait = i_req;
                d_wait = d_req;
                if (i_req || d_req) begin
                    if (rr_gnt == SRC_D) begin
                        state_d     = GNT_D;
                        lat_write_d = d_write;
                        lat_type_d  = d_type;
                        lat_addr_d  = d_addr;
                        lat_wdata_d = d_wdata;
                    end else begin
                        state_d     = GNT_I;
                        lat_write_d = 1'b0;
                        lat_type_d  = {TYPE_W{1'b1}};
                        lat_addr_d  = i_addr;
                        lat_wdata_d = '0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                m_read  = ~lat_write_q;
                m_write = lat_write_q;
                i_wait  = (state_q == GNT_I) ? m_stall : i_req;
                d_wait  = (state_q == GNT_D) ? m_stall : d_req;
                if (!m_stall) begin
                    state_d = IDLE;
                    rr_upd  = 1'b1;
                    rr_src  = (state_q == GNT_D);
                    if (state_q == GNT_I) i_rdata_d = m_rdata;
                    else                  d_rdata_d = m_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_type  = lat_type_q;
    assign m_addr  = lat_addr_q;
    assign m_wdata = lat_wdata_q;
    assign i_rdata = i_rdata_d;
    assign d_rdata = d_rdata_d;

    // State, request-field latches and held read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_write_q <= 1'b0;
            lat_type_q  <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            lat_write_q <= lat_write_d;
            lat_type_q  <= lat_type_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] perf_i_q, perf_i_d, perf_d_q, perf_d_d, perf_c_q, perf_c_d;

    // Count grants on entry to a grant state and contended idle cycles
    always_comb begin
        perf_i_d = perf_i_q + ((state_q == IDLE && state_d == GNT_I) ? 32'd1 : 32'd0);
        perf_d_d = perf_d_q + ((state_q == IDLE && state_d == GNT_D) ? 32'd1 : 32'd0);
        perf_c_d = perf_c_q + ((state_q == IDLE && i_req && d_req) ? 32'd1 : 32'd0);
    end

    // Perf counter registers, free-running with natural wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_q <= '0;
            perf_d_q <= '0;
            perf_c_q <= '0;
        end else begin
            perf_i_q <= perf_i_d;
            perf_d_q <= perf_d_d;
            perf_c_q <= perf_c_d;
        end
    end

    assign perf_i_grants  = perf_i_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_c_q;
`else
    assign perf_i_grants  = '0;
    assign perf_d_grants  = '0;
    assign perf_conflicts = '0;
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: scoreboard bench for mem_req_arbiter with a simple stalling master model
module tb_mem_req_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 0, rst = 1;
    logic        i_req = 0, d_req = 0, d_write = 0;
    logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
    logic [2:0]  d_type = 0;
    logic        i_wait, d_wait, m_read, m_write, m_stall;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [2:0]  m_type;
    logic [31:0] perf_i_grants, perf_d_grants, perf_conflicts;

    typedef struct {
        logic        src;
        logic        wr;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0;
    bit busy_prev = 0, b2b = 0, have_done = 0;
    int stall_n = 3, mcnt = 0;
    logic [31:0] mdata = 0;
    int c0;

    mem_req_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_wait(i_wait), .i_rdata(i_rdata),
        .d_req(d_req), .d_write(d_write), .d_type(d_type), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wait(d_wait), .d_rdata(d_rdata),
        .m_read(m_read), .m_write(m_write), .m_type(m_type), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata), .m_stall(m_stall),
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_conflicts(perf_conflicts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Master model: stalls stall_n cycles per transaction, then completes
    assign m_stall = (m_read | m_write) ? (mcnt < stall_n) : 1'b1;
    assign m_rdata = mdata;
    always @(posedge clk or posedge rst) begin
        if (rst) mcnt <= 0;
        else     mcnt <= ((m_read | m_write) && m_stall) ? mcnt + 1 : 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic src, input logic wr, input logic [2:0] typ,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
        exp_t e;
        e.src = src; e.wr = wr; e.typ = typ; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
        sbq.push_back(e);
    endtask

    task automatic wait_empty(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (sbq.size() == 0) return;
        end
        check("timeout", sbq.size(), 0);
        sbq.delete();
    endtask

    // Monitor: every busy cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst) busy_prev = 0;
        else begin
            if ((m_read | m_write) && !busy_prev) begin
                start_cyc = cyc;
                if (b2b && have_done) check("gap", start_cyc - done_cyc, 2);
            end
            if (m_read | m_write) begin
                if (sbq.size() == 0) check("unexpected_txn", 1, 0);
                else begin
                    exp_t e;
                    e = sbq[0];
                    check("m_write", m_write, e.wr);
                    check("m_read", m_read, !e.wr);
                    check("m_addr", m_addr, e.addr);
                    check("m_type", m_type, e.typ);
                    if (e.wr) check("m_wdata", m_wdata, e.wdata);
                    check("loser_wait", e.src ? i_wait : d_wait, e.src ? i_req : d_req);
                    if (m_stall) check("winner_wait_hi", e.src ? d_wait : i_wait, 1);
                    else begin
                        check("winner_wait_lo", e.src ? d_wait : i_wait, 0);
                        check("rdata", e.src ? d_rdata : i_rdata, e.rdata);
                        void'(sbq.pop_front());
                        done_cyc = cyc;
                        have_done = 1;
                    end
                end
            end
            busy_prev = m_read | m_write;
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_read", m_read, 0);
        check("rst_m_write", m_write, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_type", m_type, 0);
        check("rst_m_wdata", m_wdata, 0);
        check("rst_waits", {i_wait, d_wait}, 0);
        check("rst_rdata", i_rdata | d_rdata, 0);
        check("rst_perf", perf_i_grants | perf_d_grants | perf_conflicts, 0);
        rst = 0;

        // I-only read with three stall cycles
        @(posedge clk); #1;
        mdata = 32'hDEADBEEF; i_addr = 32'h0000_1000;
        push(SRC_I, 0, TYPE_ALL_ONES, 32'h0000_1000, 0, 32'hDEADBEEF);
        i_req = 1; c0 = cyc;
        wait_empty(50);
        i_req = 0;
        check("t1_start", start_cyc - c0, 1);
        check("t1_done", done_cyc - c0, 4);
        check("t1_ihold", i_rdata, 32'hDEADBEEF);

        // D byte write; inputs change under the grant, latched values must hold
        mdata = 32'h55AA55AA;
        d_write = 1; d_type = TYPE_BYTE; d_addr = 32'h0001_0004; d_wdata = 32'h1234_5678;
        push(SRC_D, 1, TYPE_BYTE, 32'h0001_0004, 32'h1234_5678, 32'h55AA55AA);
        d_req = 1;
        repeat (2) @(posedge clk);
        #1;
        d_addr = 32'hFFFF_FFFF; d_wdata = 32'h0;
        wait_empty(50);
        d_req = 0;
        check("t4_ihold", i_rdata, 32'hDEADBEEF);
        check("t4_drdata", d_rdata, 32'h55AA55AA);

        // Both requesting continuously after reset: D, I, D, I, D, I
        rst = 1; @(posedge clk); #1; rst = 0;
        stall_n = 2; mdata = 32'h0BADF00D;
        i_addr = 32'h2000; d_addr = 32'h3000; d_write = 1; d_type = TYPE_WORD; d_wdata = 32'hCAFE0000;
        for (int k = 0; k < 3; k++) begin
            push(SRC_D, 1, TYPE_WORD, 32'h3000, 32'hCAFE0000, 32'h0BADF00D);
            push(SRC_I, 0, TYPE_ALL_ONES, 32'h2000, 0, 32'h0BADF00D);
        end
        b2b = 1; have_done = 0;
        i_req = 1; d_req = 1;
        wait_empty(300);
        i_req = 0; d_req = 0; b2b = 0;
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_i", perf_i_grants, 3);
        check("perf_d", perf_d_grants, 3);
        check("perf_conf", perf_conflicts != 0, 1);
`else
        check("perf_off", perf_i_grants | perf_d_grants | perf_conflicts, 0);
`endif

        // Reset in the middle of a D grant
        stall_n = 1; d_write = 0; d_type = TYPE_HALF; d_addr = 32'h40;
        push(SRC_D, 0, TYPE_HALF, 32'h40, 0, 32'h0BADF00D);
        d_req = 1;
        wait_empty(50);
        d_req = 0;
        stall_n = 50; d_write = 1; d_addr = 32'h44; d_wdata = 32'h77;
        push(SRC_D, 1, TYPE_HALF, 32'h44, 32'h77, 32'h0BADF00D);
        d_req = 1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (m_write) break;
        end
        check("t5_grant", m_write, 1);
        rst = 1; #1;
        check("t5_m_write", m_write, 0);
        check("t5_m_read", m_read, 0);
        check("t5_state", dut.state_q, IDLE);
        sbq.delete(); d_req = 0;
        @(posedge clk); #1; rst = 0;

        // Fresh tie after reset follows the D-first rule
        stall_n = 1; mdata = 32'h13579BDF;
        i_addr = 32'h5000; d_addr = 32'h6000; d_write = 0; d_type = TYPE_WORD;
        push(SRC_D, 0, TYPE_WORD, 32'h6000, 0, 32'h13579BDF);
        push(SRC_I, 0, TYPE_ALL_ONES, 32'h5000, 0, 32'h13579BDF);
        i_req = 1; d_req = 1;
        wait_empty(100);
        i_req = 0; d_req = 0;
`ifdef MEM_ARB_PERF_CNT_EN
        check("perf_i_end", perf_i_grants, 1);
        check("perf_d_end", perf_d_grants, 1);
`else
        check("perf_off_end", perf_i_grants | perf_d_grants | perf_conflicts, 0);
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
